// File: rtl/fpu_resp_monitor_if.sv
// Bundle of issue, completion and record signals between an FPU driver/checker (master)
// and the response monitor (slave).
interface fpu_resp_monitor_if;
  logic        issue_valid;
  logic [1:0]  issue_op;
  logic [1:0]  issue_rmode;
  logic [31:0] issue_opa;
  logic [31:0] issue_opb;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic [7:0]  fpu_flags;
  logic        rec_valid;
  logic        rec_ready;
  logic [1:0]  rec_op;
  logic [1:0]  rec_rmode;
  logic [31:0] rec_opa;
  logic [31:0] rec_opb;
  logic [31:0] rec_result;
  logic [7:0]  rec_flags;
  logic [15:0] rec_latency;
  logic        err_overflow;
  logic        err_orphan;
  logic        err_drop;
  logic        err_timeout;
  logic [4:0]  outstanding;

  modport master (
    output issue_valid, issue_op, issue_rmode, issue_opa, issue_opb,
    output fpu_done, fpu_result, fpu_flags, rec_ready,
    input  rec_valid, rec_op, rec_rmode, rec_opa, rec_opb, rec_result, rec_flags, rec_latency,
    input  err_overflow, err_orphan, err_drop, err_timeout, outstanding
  );

  modport slave (
    input  issue_valid, issue_op, issue_rmode, issue_opa, issue_opb,
    input  fpu_done, fpu_result, fpu_flags, rec_ready,
    output rec_valid, rec_op, rec_rmode, rec_opa, rec_opb, rec_result, rec_flags, rec_latency,
    output err_overflow, err_orphan, err_drop, err_timeout, outstanding
  );
endinterface

// File: rtl/fpu_resp_monitor.sv
// Pairs FPU issue strobes with done strobes in order and emits timed records to a checker.
// Optional head-entry timeout detection is enabled by defining FPU_MON_TIMEOUT_EN.
module fpu_resp_monitor #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  fpu_resp_monitor_if.slave   mon
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("fpu_resp_monitor: DEPTH must be a power of 2 in 2..16 and TIMEOUT in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  rmode;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [15:0] stamp;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_next;
  logic [15:0]   stamp;
  state_t        state;

  logic accept;
  logic iss;
  logic dn;
  logic empty;
  logic full;
  logic orphan;
  logic pop;
  logic overflow;
  logic push;
  logic drop;
  logic load;
  logic handshake;
  logic timeout_hit;
  logic any_err;

  assign head = fifo_mem[rd_ptr];

`ifdef FPU_MON_TIMEOUT_EN
  logic [15:0] head_age;

  always_comb begin
    head_age    = stamp - head.stamp;
    timeout_hit = !empty && (head_age > 16'(TIMEOUT));
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Once in ERROR the strobes are masked; only the record handshake keeps running.
  always_comb begin
    accept     = (state != ERROR);
    iss        = mon.issue_valid & accept;
    dn         = mon.fpu_done & accept;
    empty      = (count == 5'd0);
    full       = (count == DEPTH_CNT);
    orphan     = dn & empty;
    pop        = dn & !empty;
    overflow   = iss & full & !pop;
    push       = iss & !overflow;
    handshake  = mon.rec_valid & mon.rec_ready;
    drop       = pop & mon.rec_valid & !mon.rec_ready;
    load       = pop & !drop;
    any_err    = orphan | overflow | drop | timeout_hit;
    count_next = count + 5'(push) - 5'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{op:    mon.issue_op,
                            rmode: mon.issue_rmode,
                            opa:   mon.issue_opa,
                            opb:   mon.issue_opb,
                            stamp: stamp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      stamp            <= 16'd0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= 5'd0;
      mon.outstanding  <= 5'd0;
      mon.rec_valid    <= 1'b0;
      mon.rec_op       <= 2'd0;
      mon.rec_rmode    <= 2'd0;
      mon.rec_opa      <= 32'd0;
      mon.rec_opb      <= 32'd0;
      mon.rec_result   <= 32'd0;
      mon.rec_flags    <= 8'd0;
      mon.rec_latency  <= 16'd0;
      mon.err_overflow <= 1'b0;
      mon.err_orphan   <= 1'b0;
      mon.err_drop     <= 1'b0;
      mon.err_timeout  <= 1'b0;
    end else begin
      stamp           <= stamp + 16'd1;
      count           <= count_next;
      mon.outstanding <= count_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (overflow)    mon.err_overflow <= 1'b1;
      if (orphan)      mon.err_orphan   <= 1'b1;
      if (drop)        mon.err_drop     <= 1'b1;
      if (timeout_hit) mon.err_timeout  <= 1'b1;

      // A load in the handshake cycle replaces the record without a gap in rec_valid.
      if (load) begin
        mon.rec_valid   <= 1'b1;
        mon.rec_op      <= head.op;
        mon.rec_rmode   <= head.rmode;
        mon.rec_opa     <= head.opa;
        mon.rec_opb     <= head.opb;
        mon.rec_result  <= mon.fpu_result;
        mon.rec_flags   <= mon.fpu_flags;
        mon.rec_latency <= stamp - head.stamp;
      end else if (handshake) begin
        mon.rec_valid   <= 1'b0;
      end

      unique case (state)
        ERROR:   state <= ERROR;
        default: begin
          if (any_err)                 state <= ERROR;
          else if (count_next == 5'd0) state <= IDLE;
          else                         state <= ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_resp_monitor.sv
// Directed-vector bench for fpu_resp_monitor; timeout expectations follow FPU_MON_TIMEOUT_EN.
module tb_fpu_resp_monitor;

  logic clk;
  logic rst;
  int   vec_count;
  int   miss_count;

  fpu_resp_monitor_if bus();

  fpu_resp_monitor #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_op    = 2'd0;
    bus.issue_rmode = 2'd0;
    bus.issue_opa   = 32'd0;
    bus.issue_opb   = 32'd0;
    bus.fpu_done    = 1'b0;
    bus.fpu_result  = 32'd0;
    bus.fpu_flags   = 8'd0;
  endtask

  task automatic set_issue(input logic [1:0] op, input logic [1:0] rm,
                           input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_rmode = rm;
    bus.issue_opa   = a;
    bus.issue_opb   = b;
  endtask

  task automatic set_done(input logic [31:0] res, input logic [7:0] fl);
    bus.fpu_done   = 1'b1;
    bus.fpu_result = res;
    bus.fpu_flags  = fl;
  endtask

  task automatic do_reset();
    clear_inputs();
    bus.rec_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_count++; if (bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_rec_valid: got %b want 0", bus.rec_valid); end
    vec_count++; if (bus.outstanding !== 5'd0) begin miss_count++; $display("[TB] FAIL reset_outstanding: got %0d want 0", bus.outstanding); end
    vec_count++; if ({bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout} !== 4'b0000) begin miss_count++; $display("[TB] FAIL reset_errs: got %b want 0000", {bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout}); end
    vec_count++; if ({bus.rec_op, bus.rec_rmode, bus.rec_opa, bus.rec_opb, bus.rec_result, bus.rec_flags, bus.rec_latency} !== 124'd0) begin miss_count++; $display("[TB] FAIL reset_rec_fields: got nonzero record %h", {bus.rec_op, bus.rec_rmode, bus.rec_opa, bus.rec_opb, bus.rec_result, bus.rec_flags, bus.rec_latency}); end
  endtask

  task automatic test_add();
    do_reset();
    bus.rec_ready = 1'b1;
    set_issue(2'd0, 2'd0, 32'h3F800000, 32'h40000000);
    step();
    clear_inputs();
    vec_count++; if (bus.outstanding !== 5'd1) begin miss_count++; $display("[TB] FAIL add_outstanding_1: got %0d want 1", bus.outstanding); end
    step();
    step();
    set_done(32'h40400000, 8'h00);
    step();
    clear_inputs();
    vec_count++; if (bus.rec_valid !== 1'b1) begin miss_count++; $display("[TB] FAIL add_rec_valid: got %b want 1", bus.rec_valid); end
    vec_count++; if (bus.rec_op !== 2'd0) begin miss_count++; $display("[TB] FAIL add_rec_op: got %0d want 0", bus.rec_op); end
    vec_count++; if (bus.rec_opa !== 32'h3F800000 || bus.rec_opb !== 32'h40000000) begin miss_count++; $display("[TB] FAIL add_operands: got %h/%h want 3f800000/40000000", bus.rec_opa, bus.rec_opb); end
    vec_count++; if (bus.rec_result !== 32'h40400000) begin miss_count++; $display("[TB] FAIL add_result: got %h want 40400000", bus.rec_result); end
    vec_count++; if (bus.rec_latency !== 16'd3) begin miss_count++; $display("[TB] FAIL add_latency: got %0d want 3", bus.rec_latency); end
    vec_count++; if (bus.outstanding !== 5'd0) begin miss_count++; $display("[TB] FAIL add_outstanding_0: got %0d want 0", bus.outstanding); end
    vec_count++; if ({bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout} !== 4'b0000) begin miss_count++; $display("[TB] FAIL add_errs: got %b want 0000", {bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout}); end
    step();
    vec_count++; if (bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL add_rec_drained: got %b want 0", bus.rec_valid); end
  endtask

  task automatic test_overflow();
    logic [1:0] ops [4];
    ops = '{2'd2, 2'd3, 2'd1, 2'd0};
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_issue(ops[i], 2'd0, 32'(i), 32'h0);
      step();
    end
    set_issue(2'd2, 2'd0, 32'h55, 32'h0);
    step();
    clear_inputs();
    vec_count++; if (bus.err_overflow !== 1'b1) begin miss_count++; $display("[TB] FAIL ovf_flag: got %b want 1", bus.err_overflow); end
    vec_count++; if (bus.outstanding !== 5'd4) begin miss_count++; $display("[TB] FAIL ovf_outstanding: got %0d want 4", bus.outstanding); end
    set_done(32'h1234, 8'h00);
    step();
    clear_inputs();
    step();
    vec_count++; if (bus.outstanding !== 5'd4 || bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL ovf_done_ignored: got outstanding=%0d rec_valid=%b want 4/0", bus.outstanding, bus.rec_valid); end
    vec_count++; if (bus.err_orphan !== 1'b0 || bus.err_drop !== 1'b0) begin miss_count++; $display("[TB] FAIL ovf_other_errs: got orphan=%b drop=%b want 0/0", bus.err_orphan, bus.err_drop); end
  endtask

  task automatic test_full_pop_push();
    logic [1:0] ops [4];
    ops = '{2'd2, 2'd3, 2'd1, 2'd0};
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_issue(ops[i], 2'(i), 32'h10 + 32'(i), 32'h0);
      step();
    end
    set_issue(2'd1, 2'd0, 32'h20, 32'h0);
    set_done(32'hCAFE0001, 8'h01);
    step();
    clear_inputs();
    vec_count++; if (bus.outstanding !== 5'd4 || bus.err_overflow !== 1'b0) begin miss_count++; $display("[TB] FAIL full_pp_count: got outstanding=%0d ovf=%b want 4/0", bus.outstanding, bus.err_overflow); end
    vec_count++; if (bus.rec_valid !== 1'b1 || bus.rec_op !== 2'd2 || bus.rec_opa !== 32'h10) begin miss_count++; $display("[TB] FAIL full_pp_head: got v=%b op=%0d opa=%h want 1/2/10", bus.rec_valid, bus.rec_op, bus.rec_opa); end
    vec_count++; if (bus.rec_latency !== 16'd4) begin miss_count++; $display("[TB] FAIL full_pp_latency: got %0d want 4", bus.rec_latency); end
    set_done(32'hCAFE0002, 8'h02);
    step();
    clear_inputs();
    vec_count++; if (bus.rec_op !== 2'd3 || bus.rec_opa !== 32'h11 || bus.rec_rmode !== 2'd1) begin miss_count++; $display("[TB] FAIL full_pp_order: got op=%0d opa=%h rm=%0d want 3/11/1", bus.rec_op, bus.rec_opa, bus.rec_rmode); end
    vec_count++; if (bus.outstanding !== 5'd3 || bus.err_drop !== 1'b0) begin miss_count++; $display("[TB] FAIL full_pp_after: got outstanding=%0d drop=%b want 3/0", bus.outstanding, bus.err_drop); end
  endtask

  task automatic test_orphan();
    do_reset();
    bus.rec_ready = 1'b1;
    set_done(32'hDEAD, 8'h00);
    step();
    clear_inputs();
    vec_count++; if (bus.err_orphan !== 1'b1) begin miss_count++; $display("[TB] FAIL orphan_flag: got %b want 1", bus.err_orphan); end
    vec_count++; if (bus.rec_valid !== 1'b0 || bus.outstanding !== 5'd0) begin miss_count++; $display("[TB] FAIL orphan_no_rec: got v=%b out=%0d want 0/0", bus.rec_valid, bus.outstanding); end
    step();
    vec_count++; if (bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL orphan_rec_stays_0: got %b want 0", bus.rec_valid); end
    do_reset();
    set_issue(2'd3, 2'd1, 32'h1, 32'h2);
    set_done(32'hBEEF, 8'h00);
    step();
    clear_inputs();
    vec_count++; if (bus.err_orphan !== 1'b1 || bus.outstanding !== 5'd1 || bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL orphan_with_issue: got orphan=%b out=%0d v=%b want 1/1/0", bus.err_orphan, bus.outstanding, bus.rec_valid); end
  endtask

  task automatic test_drop();
    do_reset();
    bus.rec_ready = 1'b0;
    set_issue(2'd1, 2'd2, 32'hA, 32'hB);
    step();
    set_issue(2'd2, 2'd3, 32'hC, 32'hD);
    step();
    clear_inputs();
    set_done(32'h11111111, 8'h01);
    step();
    clear_inputs();
    vec_count++; if (bus.rec_valid !== 1'b1 || bus.err_drop !== 1'b0) begin miss_count++; $display("[TB] FAIL drop_first_rec: got v=%b drop=%b want 1/0", bus.rec_valid, bus.err_drop); end
    step();
    set_done(32'h22222222, 8'h80);
    step();
    clear_inputs();
    vec_count++; if (bus.err_drop !== 1'b1 || bus.outstanding !== 5'd0) begin miss_count++; $display("[TB] FAIL drop_flag: got drop=%b out=%0d want 1/0", bus.err_drop, bus.outstanding); end
    vec_count++; if (bus.rec_result !== 32'h11111111 || bus.rec_flags !== 8'h01 || bus.rec_op !== 2'd1 || bus.rec_latency !== 16'd2) begin miss_count++; $display("[TB] FAIL drop_held: got res=%h fl=%h op=%0d lat=%0d want 11111111/01/1/2", bus.rec_result, bus.rec_flags, bus.rec_op, bus.rec_latency); end
    bus.rec_ready = 1'b1;
    step();
    vec_count++; if (bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL drop_drain_in_error: got %b want 0", bus.rec_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.rec_ready = 1'b1;
    set_issue(2'd0, 2'd0, 32'h1, 32'h0);
    step();
    set_issue(2'd3, 2'd2, 32'h2, 32'h0);
    step();
    clear_inputs();
    set_done(32'hAAAA0000, 8'h10);
    step();
    vec_count++; if (bus.rec_result !== 32'hAAAA0000 || bus.rec_latency !== 16'd2) begin miss_count++; $display("[TB] FAIL b2b_first: got res=%h lat=%0d want aaaa0000/2", bus.rec_result, bus.rec_latency); end
    set_done(32'hBBBB0000, 8'h20);
    step();
    clear_inputs();
    vec_count++; if (bus.rec_valid !== 1'b1 || bus.rec_result !== 32'hBBBB0000 || bus.rec_op !== 2'd3 || bus.rec_latency !== 16'd2) begin miss_count++; $display("[TB] FAIL b2b_second: got v=%b res=%h op=%0d lat=%0d want 1/bbbb0000/3/2", bus.rec_valid, bus.rec_result, bus.rec_op, bus.rec_latency); end
    vec_count++; if (bus.err_drop !== 1'b0) begin miss_count++; $display("[TB] FAIL b2b_no_drop: got %b want 0", bus.err_drop); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_issue(2'(i), 2'd0, 32'(i), 32'h0);
      step();
    end
    clear_inputs();
    rst = 1'b1;
    set_done(32'hFFFF, 8'h00);
    step();
    rst = 1'b0;
    clear_inputs();
    vec_count++; if (bus.outstanding !== 5'd0 || bus.rec_valid !== 1'b0) begin miss_count++; $display("[TB] FAIL rstmid_cleared: got out=%0d v=%b want 0/0", bus.outstanding, bus.rec_valid); end
    set_issue(2'd2, 2'd1, 32'h3F800000, 32'h3F800000);
    step();
    clear_inputs();
    step();
    set_done(32'h3F800000, 8'h00);
    step();
    clear_inputs();
    vec_count++; if (bus.rec_valid !== 1'b1 || bus.rec_latency !== 16'd2 || bus.rec_op !== 2'd2) begin miss_count++; $display("[TB] FAIL rstmid_record: got v=%b lat=%0d op=%0d want 1/2/2", bus.rec_valid, bus.rec_latency, bus.rec_op); end
    vec_count++; if ({bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout} !== 4'b0000 || bus.outstanding !== 5'd0) begin miss_count++; $display("[TB] FAIL rstmid_errs: got errs=%b out=%0d want 0000/0", {bus.err_overflow, bus.err_orphan, bus.err_drop, bus.err_timeout}, bus.outstanding); end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.rec_ready = 1'b1;
    set_issue(2'd3, 2'd0, 32'h1, 32'h0);
    step();
    clear_inputs();
`ifdef FPU_MON_TIMEOUT_EN
    repeat (16) step();
    vec_count++; if (bus.err_timeout !== 1'b0) begin miss_count++; $display("[TB] FAIL timeout_early: got %b want 0", bus.err_timeout); end
    step();
    vec_count++; if (bus.err_timeout !== 1'b1) begin miss_count++; $display("[TB] FAIL timeout_set: got %b want 1", bus.err_timeout); end
`else
    repeat (40) step();
    vec_count++; if (bus.err_timeout !== 1'b0) begin miss_count++; $display("[TB] FAIL timeout_disabled: got %b want 0", bus.err_timeout); end
    vec_count++; if (bus.outstanding !== 5'd1) begin miss_count++; $display("[TB] FAIL timeout_outstanding: got %0d want 1", bus.outstanding); end
`endif
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    rst        = 1'b1;
    bus.rec_ready = 1'b0;
    clear_inputs();
    $display("[TB] starting fpu_resp_monitor directed tests");
    test_reset();
    test_add();
    test_overflow();
    test_full_pop_push();
    test_orphan();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fpu_resp_monitor.md
FPU_RESP_MONITOR -- requirements
Module: fpu_resp_monitor

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of outstanding issued operations tracked (power of 2, 2..16).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum issue-to-done cycles before a timeout error.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 issue_valid  in  1  one-cycle strobe: the driver started one FPU operation this cycle.
REQ-006 issue_op  in  2  operation, the low bits of the op code (0 ADD, 1 SUB, 2 MUL, 3 DIV).
REQ-007 issue_rmode  in  2  rounding mode (0 nearest, 1 to-zero, 2 to-+inf, 3 to--inf).
REQ-008 issue_opa, issue_opb  in  32 each  single-precision operands.
REQ-009 fpu_done  in  1  one-cycle strobe from the DUV: result is valid.
REQ-010 fpu_result  in  32  DUV result, sampled only when fpu_done=1.
REQ-011 fpu_flags  in  8  DUV exception flags {ine,ovf,unf,inv,zero,qnan,snan,dbz}, sampled with fpu_done.
REQ-012 rec_valid  out  1  completed record available to the checker.
REQ-013 rec_ready  in  1  checker accepts the record; the transfer occurs when rec_valid & rec_ready.
REQ-014 rec_op, rec_rmode, rec_opa, rec_opb, rec_result, rec_flags  out  2/2/32/32/32/8  record fields.
REQ-015 rec_latency  out  16  cycles from the issue to the done strobe.
REQ-016 err_overflow, err_orphan, err_drop, err_timeout  out  1 each  sticky error flags.
REQ-017 outstanding  out  5  current count of tracked operations.

Function
REQ-018 Each issue_valid SHALL push {op, rmode, opa, opb, stamp} into an in-order FIFO of DEPTH entries; stamp is a free-running 16-bit cycle counter.
REQ-019 Each fpu_done SHALL pop the FIFO head and load the record register on the next edge.
REQ-020 rec_latency SHALL be (stamp at done − head stamp) mod 2^16; an issue in cycle t completed by a done in cycle t+L SHALL give L.
REQ-021 The record SHALL be registered: rec_valid rises one cycle after fpu_done and holds with stable fields until the cycle after rec_valid & rec_ready.
REQ-022 The FSM SHALL have three states:
  - IDLE: outstanding=0.
  - ACTIVE: outstanding>0.
  - ERROR: entered on any error flag being set; left only by rst.
REQ-023 In ERROR, issue_valid and fpu_done SHALL be ignored, and a pending record SHALL still drain through the handshake.
REQ-024 Simultaneous issue and done with outstanding>0 SHALL pop and push in the same cycle, count unchanged, including when outstanding=DEPTH.
REQ-025 issue_valid with outstanding=DEPTH and no same-cycle done SHALL set err_overflow and SHALL drop the issue.
REQ-026 fpu_done with outstanding=0 SHALL set err_orphan and produce no record, even if issue_valid is high in the same cycle; that issue SHALL still be enqueued.
REQ-027 fpu_done while rec_valid=1 and rec_ready=0 SHALL set err_drop, SHALL pop the head, and SHALL discard the new result; the held record is unchanged.
REQ-028 fpu_done in the same cycle as rec_valid & rec_ready SHALL load the new record without error.

Reset
REQ-029 Under rst: FIFO empty, outstanding=0, stamp counter=0, FSM=IDLE, rec_valid=0, all rec_* fields 0, all err_* flags 0.
REQ-030 rst asserted mid-operation SHALL discard all in-flight entries and any pending record; done strobes in the cycle rst is high SHALL be ignored.

Configuration
REQ-031 Macro FPU_MON_TIMEOUT_EN: when defined, err_timeout SHALL set if the head entry's age exceeds TIMEOUT cycles while outstanding>0.
REQ-032 Without FPU_MON_TIMEOUT_EN, err_timeout SHALL be tied 0 and no age comparison logic SHALL exist.

Verification
REQ-033 ADD issue, opa=0x3F800000, opb=0x40000000, rmode=0; done 3 cycles later with result=0x40400000, flags=0; rec_ready=1 -> one record: op=0, result 0x40400000, rec_latency=3, no errors.
REQ-034 Four back-to-back issues (MUL, DIV, SUB, ADD) then a fifth with no done -> err_overflow=1, FSM=ERROR, outstanding=4; later dones are ignored.
REQ-035 fpu_done after reset with no issue -> err_orphan=1, rec_valid stays 0.
REQ-036 Two issues, rec_ready held 0, two dones 2 cycles apart -> first record held, err_drop=1, outstanding=0.
REQ-037 FPU_MON_TIMEOUT_EN with TIMEOUT=16, one issue, no done -> err_timeout=1 at age 17; without the macro -> err_timeout stays 0.
REQ-038 Three issues, rst pulsed for 1 cycle, then one issue and a done 2 cycles later -> no errors, single record with rec_latency=2.
